// File: rtl/id_hazard_scoreboard.sv
// Decode-stage countdown scoreboard: tracks pending writes from variable-latency producers
// and issues stall/bubble control. Optional macro SB_FWD_EN enables final-cycle EX/MEM forwarding.
module id_hazard_scoreboard #(
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rs1Addr_id,
  input  logic [AW-1:0]    rs2Addr_id,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic [AW-1:0]    rdAddr_id,
  input  logic             RegWrite_id,
  input  logic [LAT_W-1:0] lat_id,
  input  logic             valid_id,
  input  logic             flush,
  output logic             Stall,
  output logic             IFWrite,
  output logic             Bubble,
  output logic [NREG-1:0]  busy
);

  localparam int NADDR = 1 << AW;

  logic [LAT_W-1:0] cnt_q [NREG];
  logic [LAT_W-1:0] cnt_d [NREG];

  // Full address-space view of the counters; x0 and addresses >= NREG read as idle.
  logic [LAT_W-1:0] cnt_rd [NADDR];

  genvar gi;
  generate
    for (gi = 0; gi < NADDR; gi++) begin : g_rd
      if (gi > 0 && gi < NREG) begin : g_live
        assign cnt_rd[gi] = cnt_q[gi];
      end else begin : g_zero
        assign cnt_rd[gi] = '0;
      end
    end

    for (gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_x0
        assign busy[gi] = 1'b0;
      end else begin : g_reg
        assign busy[gi] = (cnt_q[gi] != '0);
      end
    end
  endgenerate

  function automatic logic hz(input logic [LAT_W-1:0] c);
`ifdef SB_FWD_EN
    return c > LAT_W'(1);
`else
    return c != '0;
`endif
  endfunction

  logic [LAT_W-1:0] cnt_rs1;
  logic [LAT_W-1:0] cnt_rs2;
  logic [LAT_W-1:0] cnt_rd_dst;
  logic             tracked_wr;
  logic             raw1;
  logic             raw2;
  logic             waw;
  logic             issue;

  assign cnt_rs1    = cnt_rd[rs1Addr_id];
  assign cnt_rs2    = cnt_rd[rs2Addr_id];
  assign cnt_rd_dst = cnt_rd[rdAddr_id];

  assign tracked_wr = RegWrite_id && (rdAddr_id != '0) && (lat_id != '0);

  assign raw1 = rs1_used && (rs1Addr_id != '0) && hz(cnt_rs1);
  assign raw2 = rs2_used && (rs2Addr_id != '0) && hz(cnt_rs2);
  // A shorter new write must not retire before an older, slower one to the same rd.
  assign waw  = tracked_wr && (cnt_rd_dst > lat_id);

  assign Stall   = valid_id && !flush && (raw1 || raw2 || waw);
  assign IFWrite = !Stall;
  assign Bubble  = Stall || flush;
  assign issue   = valid_id && !Stall && !flush && tracked_wr;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (issue && (rdAddr_id == AW'(r))) begin
        cnt_d[r] = lat_id;
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed bench for id_hazard_scoreboard; stimulus queues expected outputs per cycle,
// a monitor pops and compares them on the falling edge.
module tb_id_hazard_scoreboard;

  localparam int NREG  = 32;
  localparam int AW    = 5;
  localparam int LAT_W = 3;
`ifdef SB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [AW-1:0]    rs1Addr_id = '0;
  logic [AW-1:0]    rs2Addr_id = '0;
  logic             rs1_used = 1'b0;
  logic             rs2_used = 1'b0;
  logic [AW-1:0]    rdAddr_id = '0;
  logic             RegWrite_id = 1'b0;
  logic [LAT_W-1:0] lat_id = '0;
  logic             valid_id = 1'b0;
  logic             flush = 1'b0;
  logic             Stall;
  logic             IFWrite;
  logic             Bubble;
  logic [NREG-1:0]  busy;

  id_hazard_scoreboard #(.NREG(NREG), .AW(AW), .LAT_W(LAT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id),
    .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rdAddr_id(rdAddr_id), .RegWrite_id(RegWrite_id), .lat_id(lat_id),
    .valid_id(valid_id), .flush(flush),
    .Stall(Stall), .IFWrite(IFWrite), .Bubble(Bubble), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic            stall;
    logic            bubble;
    logic            ifwrite;
    logic [NREG-1:0] busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // One cycle: drive ID inputs just after the rising edge, queue what the outputs must be.
  task automatic cyc(input string nm, input logic rst, input logic v,
                     input logic r1u, input logic [AW-1:0] r1,
                     input logic r2u, input logic [AW-1:0] r2,
                     input logic rw, input logic [AW-1:0] rd, input logic [LAT_W-1:0] lat,
                     input logic fl, input logic st, input logic [NREG-1:0] bz);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; valid_id = v;
    rs1_used = r1u; rs1Addr_id = r1; rs2_used = r2u; rs2Addr_id = r2;
    RegWrite_id = rw; rdAddr_id = rd; lat_id = lat; flush = fl;
    e.name = nm; e.stall = st; e.bubble = st | fl; e.ifwrite = ~st; e.busy = bz;
    exp_q.push_back(e);
  endtask

  task automatic idle(input string nm, input logic [NREG-1:0] bz);
    cyc(nm, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, bz);
  endtask

  task automatic wr(input string nm, input logic [AW-1:0] rd, input logic [LAT_W-1:0] lat,
                    input logic st, input logic [NREG-1:0] bz);
    cyc(nm, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, rd, lat, 1'b0, st, bz);
  endtask

  task automatic rd1(input string nm, input logic [AW-1:0] r, input logic fl,
                     input logic st, input logic [NREG-1:0] bz);
    cyc(nm, 1'b1, 1'b1, 1'b1, r, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0, fl, st, bz);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (Stall !== e.stall || Bubble !== e.bubble || IFWrite !== e.ifwrite || busy !== e.busy) begin
          n_err++;
          $display("FAIL %s: got Stall=%b Bubble=%b IFWrite=%b busy=%h, want Stall=%b Bubble=%b IFWrite=%b busy=%h",
                   e.name, Stall, Bubble, IFWrite, busy, e.stall, e.bubble, e.ifwrite, e.busy);
        end else begin
          $display("ok   %s: Stall=%b Bubble=%b IFWrite=%b busy=%h", e.name, Stall, Bubble, IFWrite, busy);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

  localparam logic [NREG-1:0] B3 = 32'h0000_0008;
  localparam logic [NREG-1:0] B5 = 32'h0000_0020;
  localparam logic [NREG-1:0] B7 = 32'h0000_0080;
  localparam logic [NREG-1:0] B9 = 32'h0000_0200;

  initial begin : stimulus
    // Reset state, then a plain reset release.
    cyc("reset_hold", 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, '0);
    cyc("reset_flush", 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b1, 1'b0, '0);
    idle("post_reset", '0);

    // Load-use on x5 with latency 3.
    wr ("lu_issue", 5'd5, 3'd3, 1'b0, '0);
    rd1("lu_c1", 5'd5, 1'b0, 1'b1, B5);
    rd1("lu_c2", 5'd5, 1'b0, 1'b1, B5);
    rd1("lu_c3", 5'd5, 1'b0, !FWD, B5);
    rd1("lu_c4", 5'd5, 1'b0, 1'b0, '0);

    // Async reset in the middle of a countdown.
    wr  ("rst_issue", 5'd5, 3'd3, 1'b0, '0);
    idle("rst_pending", B5);
    cyc ("rst_assert", 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, '0);
    rd1 ("rst_release_reader", 5'd5, 1'b0, 1'b0, '0);

    // x0 is never tracked; unused sources never stall.
    wr  ("x0_issue", 5'd0, 3'd5, 1'b0, '0);
    cyc ("x0_reader", 1'b1, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, '0);
    wr  ("x7_issue", 5'd7, 3'd4, 1'b0, '0);
    cyc ("x7_unused", 1'b1, 1'b1, 1'b0, 5'd7, 1'b0, 5'd7, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, B7);
    cyc ("x7_rs2_used", 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 3'd0, 1'b0, 1'b1, B7);
    idle("x7_cnt2", B7);
    idle("x7_cnt1", B7);
    idle("x7_clear", '0);

    // WAW: shorter write waits until older one has at most lat cycles left.
    wr  ("waw_seed", 5'd9, 3'd4, 1'b0, '0);
    wr  ("waw_cnt4", 5'd9, 3'd2, 1'b1, B9);
    wr  ("waw_cnt3", 5'd9, 3'd2, 1'b1, B9);
    wr  ("waw_cnt2_issue", 5'd9, 3'd2, 1'b0, B9);
    idle("waw_loaded2", B9);
    idle("waw_cnt1", B9);
    idle("waw_clear", '0);

    // WAW with longer new latency: no stall, counter reloads to 6.
    wr  ("waw6_seed", 5'd9, 3'd4, 1'b0, '0);
    wr  ("waw6_issue", 5'd9, 3'd6, 1'b0, B9);
    for (int k = 6; k >= 2; k--) idle($sformatf("waw6_cnt%0d", k), B9);
    idle("waw6_cnt1", B9);
    idle("waw6_clear", '0);

    // Flush beats a hazard; pending counters keep running.
    wr  ("fl_issue", 5'd5, 3'd3, 1'b0, '0);
    rd1 ("fl_flush", 5'd5, 1'b1, 1'b0, B5);
    rd1 ("fl_cnt2", 5'd5, 1'b0, 1'b1, B5);
    rd1 ("fl_cnt1", 5'd5, 1'b0, !FWD, B5);
    rd1 ("fl_clear", 5'd5, 1'b0, 1'b0, '0);
    cyc ("fl_kill_write", 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd6, 3'd3, 1'b1, 1'b0, '0);
    idle("fl_killed", '0);

    // Re-issue onto a counter about to expire: issue wins.
    wr  ("re_seed", 5'd3, 3'd1, 1'b0, '0);
    wr  ("re_issue", 5'd3, 3'd4, 1'b0, B3);
    idle("re_cnt4", B3);
    idle("re_cnt3", B3);
    idle("re_cnt2", B3);
    idle("re_cnt1", B3);
    idle("re_clear", '0);

    // A bubble in ID never stalls even when its sources are busy.
    wr  ("bub_issue", 5'd5, 3'd2, 1'b0, '0);
    cyc ("bub_reader", 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0, B5);
    idle("bub_cnt1", B5);
    idle("bub_clear", '0);

    @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
